// File: rtl/psram_pkg.sv
// Shared definitions for the QSPI PSRAM responder: FSM state encoding,
// command codes and frame field lengths.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } psram_state_e;

    localparam logic [7:0] PSRAM_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] PSRAM_CMD_QWRITE = 8'h38;
    localparam int         ADDR_NIBBLES     = 6;
    localparam int         CMD_BITS         = 8;

endpackage

// File: rtl/psram_qspi_responder_if.sv
// QSPI bus between a PSRAM controller (master) and the device (slave).
//   sck    : serial clock, driven by the controller
//   ce_n   : chip enable, active low, driven by the controller
//   din    : io[3:0] toward the device
//   dout   : io[3:0] toward the controller
//   douten : device output enable, all bits equal
interface psram_qspi_responder_if;
    logic       sck;
    logic       ce_n;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] douten;

    modport master (output sck, ce_n, din, input dout, douten);
    modport slave  (input sck, ce_n, din, output dout, douten);
endinterface

// File: rtl/psram_byte_mem.sv
// DEPTH x 8 byte array for the PSRAM responder.
//   clk               : system clock
//   q_we/q_wdata      : QSPI write strobe and data
//   q_addr/q_rdata    : QSPI address (shared by read and write), read data
//   bd_we/bd_wdata    : backdoor write strobe and data
//   bd_addr/bd_rdata  : backdoor address and combinational read data
// There is one write port; a QSPI write takes it over a backdoor write in
// the same clock. Contents are never reset.
module psram_byte_mem #(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          q_we,
    input  logic [AW-1:0] q_addr,
    input  logic [7:0]    q_wdata,
    output logic [7:0]    q_rdata,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [7:0]    bd_wdata,
    output logic [7:0]    bd_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (q_we) begin
            mem[q_addr] <= q_wdata;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    assign q_rdata  = mem[q_addr];
    assign bd_rdata = mem[bd_addr];

endmodule

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device responder. Oversamples sck on the system clock and
// serves EBh quad read and 38h quad write from an internal byte array.
//   clk      : system clock (same as the controller)
//   rst      : asynchronous active-high reset
//   bus      : QSPI slave side (sck, ce_n, din, dout, douten)
//   bd_*     : backdoor byte access for bench preload / inspection
//   busy     : ce_n low and a transaction in progress
module psram_qspi_responder
    import psram_pkg::*;
#(
    parameter int         DEPTH        = 1024,
    parameter int         DUMMY_CYCLES = 6,
    parameter logic [7:0] CMD_QREAD    = PSRAM_CMD_QREAD,
    parameter logic [7:0] CMD_QWRITE   = PSRAM_CMD_QWRITE,
    localparam int        AW           = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    psram_qspi_responder_if.slave          bus,
    input  logic                           bd_we,
    input  logic [AW-1:0]                  bd_addr,
    input  logic [7:0]                     bd_wdata,
    output logic [7:0]                     bd_rdata,
    output logic                           busy
);

    psram_state_e  state_q, state_d;
    logic          sck_q;
    logic          ce_q;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          is_wr_q, is_wr_d;
    logic          half_q, half_d;
    logic [3:0]    hi_q, hi_d;
    logic [3:0]    dout_q, dout_d;
    logic [3:0]    douten_q, douten_d;

    logic          rise, fall;
    logic [7:0]    cmd_next;
    logic          q_we;
    logic [7:0]    q_rdata;

    assign rise     = bus.sck & ~sck_q;
    assign fall     = ~bus.sck & sck_q;
    assign cmd_next = {cmd_q[6:0], bus.din[0]};

    psram_byte_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .q_we     (q_we),
        .q_addr   (addr_q),
        .q_wdata  ({hi_q, bus.din}),
        .q_rdata  (q_rdata),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sck_q    <= 1'b0;
            // Reset to "ce_n low seen" so a chip enable still held low
            // across reset release does not start a frame.
            ce_q     <= 1'b0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            is_wr_q  <= 1'b0;
            half_q   <= 1'b0;
            hi_q     <= '0;
            dout_q   <= '0;
            douten_q <= '0;
        end else begin
            state_q  <= state_d;
            sck_q    <= bus.sck;
            ce_q     <= bus.ce_n;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            is_wr_q  <= is_wr_d;
            half_q   <= half_d;
            hi_q     <= hi_d;
            dout_q   <= dout_d;
            douten_q <= douten_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        is_wr_d  = is_wr_q;
        half_d   = half_q;
        hi_d     = hi_q;
        dout_d   = dout_q;
        douten_d = douten_q;
        q_we     = 1'b0;

        if (bus.ce_n) begin
            // Deselect ends any frame; a pending half byte is dropped.
            state_d  = ST_IDLE;
            douten_d = '0;
            cnt_d    = '0;
            half_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Only a high-to-low chip enable edge opens a frame.
                    if (ce_q) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                        half_d  = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_d = cmd_next;
                        if (cnt_q == 8'(CMD_BITS - 1)) begin
                            cnt_d = '0;
                            if (cmd_next == CMD_QREAD) begin
                                state_d = ST_ADDR;
                                is_wr_d = 1'b0;
                            end else if (cmd_next == CMD_QWRITE) begin
                                state_d = ST_ADDR;
                                is_wr_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        // Upper address bits fall off the top: aliasing.
                        addr_d = AW'({addr_q, bus.din});
                        if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
                            cnt_d  = '0;
                            half_d = 1'b0;
                            if (is_wr_q) begin
                                state_d = ST_WDATA;
                            end else if (DUMMY_CYCLES == 0) begin
                                state_d = ST_RDATA;
                            end else begin
                                state_d = ST_DUMMY;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    // Drive on fall so the controller can sample on rise.
                    // The array is read at the fall itself, so late
                    // backdoor writes to the byte are still picked up.
                    if (fall) begin
                        douten_d = 4'hF;
                        if (!half_q) begin
                            dout_d = q_rdata[7:4];
                            half_d = 1'b1;
                        end else begin
                            dout_d = q_rdata[3:0];
                            half_d = 1'b0;
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        if (!half_q) begin
                            hi_d   = bus.din;
                            half_d = 1'b1;
                        end else begin
                            q_we   = 1'b1;
                            half_d = 1'b0;
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                ST_IGNORE: begin
                    douten_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dout   = dout_q;
    assign bus.douten = douten_q;
    assign busy       = ~bus.ce_n & (state_q != ST_IDLE);

endmodule

// File: doc/psram_qspi_responder.md
Name: psram_qspi_responder

Overview:
- Synthesizable QSPI PSRAM device responder. It is the far end of the sck/ce_n/dout/douten/din bus driven by the PSRAM controller.
- Decodes the serial command byte, the quad address and quad data, and serves EBh quad read and 38h quad write from an internal byte array.
- Used as the on-chip device in FPGA/SoC integration benches and as the reference responder for controller verification.
- Runs on the system clock and oversamples sck; it never clocks on sck.

Parameters:
- DEPTH, 1024, memory size in bytes; power of two. AW = clog2(DEPTH).
- DUMMY_CYCLES, 6, sck rising edges between the last address nibble and the first read data nibble.
- CMD_QREAD, 8'hEB, quad read command code.
- CMD_QWRITE, 8'h38, quad write command code.

Ports:
- clk  in  1  system clock; same clock as the controller.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  serial clock from controller.
- ce_n  in  1  chip enable from controller, active low.
- din  in  4  controller's dout (io[3:0] toward device).
- dout  out  4  read data nibble toward controller.
- douten  out  4  output enable; all bits equal.
- bd_we  in  1  backdoor byte write strobe (bench preload).
- bd_addr  in  AW  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data; combinational from the array.
- busy  out  1  high while ce_n is low and state is not IDLE.

Behaviour:
- Reset: state=IDLE, dout=0, douten=0, busy=0, all counters 0. Array contents are not reset.
- Sampling:
  - sck_q and ce_q are registered each clk.
  - rise = sck & ~sck_q; fall = ~sck & sck_q.
  - Requirement on the controller: sck high and low each ≥1 clk, so f_sck ≤ f_clk/2.
- Framing:
  - ce_n high in any state → IDLE next clk; douten=0; partial byte discarded.
  - Memory writes already committed are kept.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE → CMD on ce_n low.
- CMD:
  - 8 rises; shift in din[0], MSB first.
  - After the 8th: CMD_QREAD → ADDR(read); CMD_QWRITE → ADDR(write); anything else → IGNORE.
- ADDR:
  - 6 rises; shift din[3:0], high nibble first, into a 24-bit address.
  - Only addr[AW-1:0] is used; upper bits are ignored (aliasing).
  - Read → DUMMY; write → WDATA.
- DUMMY: count DUMMY_CYCLES rises, then → RDATA. If DUMMY_CYCLES=0, go straight to RDATA.
- RDATA:
  - On the first fall after entry: douten=4'hF, dout=mem[addr][7:4].
  - Each later fall alternates dout between the low nibble and the high nibble of the next byte. addr increments after the low nibble.
  - The controller samples on rise.
- WDATA:
  - Each rise shifts a nibble, high nibble first.
  - On the 2nd nibble, write mem[addr]={hi,lo} in that clk, then addr+1.
- Address wraps from DEPTH-1 to 0 in both directions; no burst length limit.
- IGNORE: douten=0; hold until ce_n high.
- Simultaneous bd_we and a QSPI write to the same byte in one clk: QSPI wins.
- A backdoor write during RDATA is visible if it lands before the byte's high-nibble fall.
- Reset asserted mid-transaction: immediate IDLE and douten=0. On release with ce_n still low, the responder stays IDLE until ce_n goes high, then low again.

Decomposition:
- Shared package psram_pkg: state enum, command codes (8'hEB, 8'h38), ADDR_NIBBLES=6, CMD_BITS=8.
- One sub-module: psram_byte_mem. Single write port is muxed QSPI/backdoor; one read port for QSPI, one for backdoor; DEPTH x 8.

Test Plan:
- Reset: assert rst mid-RDATA → douten=0, dout=0, busy=0 within 0 clk (async); next EBh read with ce_n re-asserted works.
- Backdoor preload mem[0x10..0x13]=11,22,33,44; EBh to addr 0x000010, 6 dummies, 8 data clocks → nibbles 1,1,2,2,3,3,4,4; controller word 0x44332211.
- 38h to addr 0x000020 with data nibbles A,B,C,D → bd_rdata at 0x20=8'hAB and 0x21=8'hCD; 0x22 unchanged.
- Wrap: EBh to addr DEPTH-1 for 2 bytes → returns mem[DEPTH-1] then mem[0]. 38h at DEPTH-1 for 2 bytes → mem[0] written.
- Unknown command 8'h9F → douten stays 0 for the whole ce_n-low window; memory unchanged; next transaction decodes normally.
- Abort: ce_n high after 3 nibbles of a 38h write → only byte 0 written; half byte dropped; state=IDLE next clk.
